// File: rtl/phy_mem_arbiter_if.sv
// Requester handshakes and controller-facing bus of phy_mem_arbiter.
// slave = the arbiter, master = requesters plus the memory controller.
interface phy_mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic        dma_req;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_ack;
  logic [31:0] rdata;
  logic        mem_is_write;
  logic        mem_opt_is_lw;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic        mem_busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata, mem_data_out, mem_busy,
    output if_ack, d_ack, dma_ack, rdata,
    output mem_is_write, mem_opt_is_lw, mem_addr, mem_data_in
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata, mem_data_out, mem_busy,
    input  if_ack, d_ack, dma_ack, rdata,
    input  mem_is_write, mem_opt_is_lw, mem_addr, mem_data_in
  );
endinterface

// File: rtl/phy_mem_arbiter.sv
// Three-port arbiter/sequencer (fetch, data, DMA) in front of phy_mem_ctrl.
// All state moves on the falling edge of clk50M, like the controller.
module phy_mem_arbiter #(
  parameter logic [31:0] IDLE_ADDR    = 32'h0000_0000,
  parameter int          DMA_MAX_WAIT = 16
) (
  input  logic             clk50M,
  input  logic             rst,
  phy_mem_arbiter_if.slave bus
);

  localparam int                WAIT_W   = $clog2(DMA_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(DMA_MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RD       = 2'd1,
    S_WR_PULSE = 2'd2,
    S_WR_WAIT  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OWN_IF  = 2'd0,
    OWN_D   = 2'd1,
    OWN_DMA = 2'd2
  } owner_t;

  state_t            state_r, state_s;
  owner_t            owner_r, owner_s, gnt_owner_s;
  logic              gnt_valid_s, gnt_we_s;
  logic [31:0]       gnt_addr_s, gnt_wdata_s;
  logic [WAIT_W-1:0] dma_wait_r, dma_wait_s;
  logic [2:0]        ack_r, ack_s;
  logic [31:0]       rdata_r, rdata_s;
  logic              mem_is_write_r, mem_is_write_s;
  logic              mem_opt_is_lw_r, mem_opt_is_lw_s;
  logic [31:0]       mem_addr_r, mem_addr_s;
  logic [31:0]       mem_data_in_r, mem_data_in_s;
  logic              if_pend_s, d_pend_s, dma_pend_s, starved_s;

  function automatic logic [2:0] ack_onehot(input owner_t own);
    case (own)
      OWN_IF:  return 3'b001;
      OWN_D:   return 3'b010;
      OWN_DMA: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // A req seen in the same cycle as its own ack belongs to the finished access.
  assign if_pend_s  = bus.if_req  & ~ack_r[0];
  assign d_pend_s   = bus.d_req   & ~ack_r[1];
  assign dma_pend_s = bus.dma_req & ~ack_r[2];
  assign starved_s  = (dma_wait_r == WAIT_MAX);

  // Arbitration: starved DMA, then data, then fetch, then DMA.
  always_comb begin
    gnt_valid_s = 1'b1;
    gnt_owner_s = OWN_IF;
    gnt_we_s    = 1'b0;
    gnt_addr_s  = bus.if_addr;
    gnt_wdata_s = 32'h0000_0000;
    if (dma_pend_s && starved_s) begin
      gnt_owner_s = OWN_DMA;
      gnt_we_s    = bus.dma_we;
      gnt_addr_s  = bus.dma_addr;
      gnt_wdata_s = bus.dma_wdata;
    end else if (d_pend_s) begin
      gnt_owner_s = OWN_D;
      gnt_we_s    = bus.d_we;
      gnt_addr_s  = bus.d_addr;
      gnt_wdata_s = bus.d_wdata;
    end else if (if_pend_s) begin
      gnt_owner_s = OWN_IF;
    end else if (dma_pend_s) begin
      gnt_owner_s = OWN_DMA;
      gnt_we_s    = bus.dma_we;
      gnt_addr_s  = bus.dma_addr;
      gnt_wdata_s = bus.dma_wdata;
    end else begin
      gnt_valid_s = 1'b0;
    end
  end

  // Next state and next registered outputs; the bus parks on IDLE_ADDR by default.
  always_comb begin
    state_s         = state_r;
    owner_s         = owner_r;
    dma_wait_s      = dma_wait_r;
    ack_s           = 3'b000;
    rdata_s         = rdata_r;
    mem_is_write_s  = 1'b0;
    mem_opt_is_lw_s = 1'b0;
    mem_addr_s      = IDLE_ADDR;
    mem_data_in_s   = mem_data_in_r;
    case (state_r)
      S_IDLE: begin
        if (gnt_valid_s) begin
          owner_s    = gnt_owner_s;
          mem_addr_s = gnt_addr_s;
          if (gnt_we_s) begin
            state_s        = S_WR_PULSE;
            mem_is_write_s = 1'b1;
            mem_data_in_s  = gnt_wdata_s;
          end else begin
            state_s         = S_RD;
            mem_opt_is_lw_s = (gnt_owner_s != OWN_IF);
          end
        end else begin
          state_s = S_IDLE;
        end
        if (gnt_valid_s && (gnt_owner_s == OWN_DMA)) begin
          dma_wait_s = {WAIT_W{1'b0}};
        end else if (dma_pend_s && !starved_s) begin
          dma_wait_s = dma_wait_r + WAIT_ONE;
        end else begin
          dma_wait_s = dma_wait_r;
        end
      end
      S_RD: begin
        state_s = S_IDLE;
        rdata_s = bus.mem_data_out;
        ack_s   = ack_onehot(owner_r);
      end
      S_WR_PULSE: begin
        // Dropping mem_is_write here guarantees a low cycle between writes.
        state_s = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (!bus.mem_busy) begin
          state_s = S_IDLE;
          ack_s   = ack_onehot(owner_r);
        end else begin
          state_s = S_WR_WAIT;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(negedge clk50M) begin
    if (rst) begin
      state_r         <= S_IDLE;
      owner_r         <= OWN_IF;
      dma_wait_r      <= {WAIT_W{1'b0}};
      ack_r           <= 3'b000;
      rdata_r         <= 32'h0000_0000;
      mem_is_write_r  <= 1'b0;
      mem_opt_is_lw_r <= 1'b0;
      mem_addr_r      <= IDLE_ADDR;
      mem_data_in_r   <= 32'h0000_0000;
    end else begin
      state_r         <= state_s;
      owner_r         <= owner_s;
      dma_wait_r      <= dma_wait_s;
      ack_r           <= ack_s;
      rdata_r         <= rdata_s;
      mem_is_write_r  <= mem_is_write_s;
      mem_opt_is_lw_r <= mem_opt_is_lw_s;
      mem_addr_r      <= mem_addr_s;
      mem_data_in_r   <= mem_data_in_s;
    end
  end

  assign bus.if_ack        = ack_r[0];
  assign bus.d_ack         = ack_r[1];
  assign bus.dma_ack       = ack_r[2];
  assign bus.rdata         = rdata_r;
  assign bus.mem_is_write  = mem_is_write_r;
  assign bus.mem_opt_is_lw = mem_opt_is_lw_r;
  assign bus.mem_addr      = mem_addr_r;
  assign bus.mem_data_in   = mem_data_in_r;

endmodule
